// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequencer driving an external Hack ALU, with optional shift-add multiply
//
// Purpose: accepts a command (op, x, y) and runs it through an external Hack ALU.
//   Ops 0..15 take a single ALU cycle. Op 16 is a 16-cycle shift-add multiply built
//   from repeated ALU adds; it is only present when ALU_SEQ_MUL_EN is defined.
//   Any other op returns an error response.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake; cmd_op[4:0], cmd_x, cmd_y payload
//   rsp_valid/rsp_ready           response handshake; rsp_o, rsp_zr, rsp_ng, rsp_err payload
//   zx, nx, zy, ny, f, no         control bits to the external ALU
//   alu_x, alu_y                  operands to the external ALU
//   alu_o, alu_zr, alu_ng         result and flags from the external ALU
//   busy                          high whenever the sequencer is not idle
//
// Build option: ALU_SEQ_MUL_EN compiles in the MUL state, iteration counter and
//   multiplier shift register.

module alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_op,
    input  logic [15:0] cmd_x,
    input  logic [15:0] cmd_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_o,
    output logic        rsp_zr,
    output logic        rsp_ng,
    output logic        rsp_err,
    output logic        zx,
    output logic        nx,
    output logic        zy,
    output logic        ny,
    output logic        f,
    output logic        no,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    input  logic [15:0] alu_o,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic        busy
);

    // Control words are ordered {zx, nx, zy, ny, f, no}.
    localparam logic [5:0] CTL_ZERO  = 6'b101010;
    localparam logic [5:0] CTL_ADD   = 6'b000010;
    localparam logic [5:0] CTL_PASSX = 6'b001100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
`ifdef ALU_SEQ_MUL_EN
        ,
        MUL  = 2'd3
`endif
    } state_t;

    state_t      state_q;
    logic        cmd_ready_q;
    logic        busy_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_o_q;
    logic        rsp_zr_q;
    logic        rsp_ng_q;
    logic        rsp_err_q;
    logic [5:0]  ctl_q;
    // During MUL these two double as the accumulator (alu_x_q) and the
    // left-shifting multiplicand (alu_y_q), so the ALU always sees acc + mcand.
    logic [15:0] alu_x_q;
    logic [15:0] alu_y_q;

`ifdef ALU_SEQ_MUL_EN
    logic [3:0]  cnt_q;
    logic [15:0] mplier_q;
    logic [15:0] mplier_d;

    assign mplier_d = mplier_q >> 1;
`endif

    function automatic logic [5:0] decode(input logic [3:0] op);
        logic [5:0] c;
        case (op)
            4'd0:    c = 6'b101010;
            4'd1:    c = 6'b111111;
            4'd2:    c = 6'b111010;
            4'd3:    c = 6'b001100;
            4'd4:    c = 6'b110000;
            4'd5:    c = 6'b001101;
            4'd6:    c = 6'b110001;
            4'd7:    c = 6'b001111;
            4'd8:    c = 6'b110011;
            4'd9:    c = 6'b011111;
            4'd10:   c = 6'b110111;
            4'd11:   c = 6'b000010;
            4'd12:   c = 6'b010011;
            4'd13:   c = 6'b000111;
            4'd14:   c = 6'b000000;
            default: c = 6'b010101;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_o_q     <= 16'd0;
            rsp_zr_q    <= 1'b0;
            rsp_ng_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            ctl_q       <= CTL_ZERO;
            alu_x_q     <= 16'd0;
            alu_y_q     <= 16'd0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q       <= 4'd0;
            mplier_q    <= 16'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // cmd_ready is always high here, so cmd_valid alone accepts.
                    if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (!cmd_op[4]) begin
                            state_q <= EXEC;
                            ctl_q   <= decode(cmd_op[3:0]);
                            alu_x_q <= cmd_x;
                            alu_y_q <= cmd_y;
                        end
`ifdef ALU_SEQ_MUL_EN
                        else if (cmd_op == 5'd16) begin
                            state_q  <= MUL;
                            cnt_q    <= 4'd0;
                            mplier_q <= cmd_y;
                            ctl_q    <= cmd_y[0] ? CTL_ADD : CTL_PASSX;
                            alu_x_q  <= 16'd0;
                            alu_y_q  <= cmd_x;
                        end
`endif
                        else begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_o_q     <= 16'd0;
                            rsp_zr_q    <= 1'b1;
                            rsp_ng_q    <= 1'b0;
                            rsp_err_q   <= 1'b1;
                        end
                    end
                end

                EXEC: begin
                    state_q     <= RESP;
                    rsp_valid_q <= 1'b1;
                    rsp_o_q     <= alu_o;
                    rsp_zr_q    <= alu_zr;
                    rsp_ng_q    <= alu_ng;
                    rsp_err_q   <= 1'b0;
                    ctl_q       <= CTL_ZERO;
                    alu_x_q     <= 16'd0;
                    alu_y_q     <= 16'd0;
                end

`ifdef ALU_SEQ_MUL_EN
                MUL: begin
                    mplier_q <= mplier_d;
                    rsp_zr_q <= alu_zr;
                    rsp_ng_q <= alu_ng;
                    if (cnt_q == 4'd15) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_o_q     <= alu_o;
                        rsp_err_q   <= 1'b0;
                        ctl_q       <= CTL_ZERO;
                        alu_x_q     <= 16'd0;
                        alu_y_q     <= 16'd0;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        // Control for the next iteration looks at the bit that
                        // becomes mplier[0] after this edge's shift.
                        ctl_q   <= mplier_d[0] ? CTL_ADD : CTL_PASSX;
                        alu_x_q <= alu_o;
                        alu_y_q <= alu_y_q << 1;
                    end
                end
`endif

                RESP: begin
                    // Returning through IDLE guarantees at least one idle cycle
                    // between consuming a response and accepting the next command.
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    ctl_q       <= CTL_ZERO;
                    alu_x_q     <= 16'd0;
                    alu_y_q     <= 16'd0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_o     = rsp_o_q;
    assign rsp_zr    = rsp_zr_q;
    assign rsp_ng    = rsp_ng_q;
    assign rsp_err   = rsp_err_q;
    assign zx        = ctl_q[5];
    assign nx        = ctl_q[4];
    assign zy        = ctl_q[3];
    assign ny        = ctl_q[2];
    assign f         = ctl_q[1];
    assign no        = ctl_q[0];
    assign alu_x     = alu_x_q;
    assign alu_y     = alu_y_q;

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have ports cmd_valid (in, 1), cmd_ready (out, 1), cmd_op (in, 5), cmd_x (in, 16), cmd_y (in, 16): command channel.
REQ-004 SHALL have ports rsp_valid (out, 1), rsp_ready (in, 1), rsp_o (out, 16), rsp_zr (out, 1), rsp_ng (out, 1), rsp_err (out, 1): response channel.
REQ-005 SHALL have ports zx, nx, zy, ny, f, no (out, 1 each), alu_x, alu_y (out, 16): drive the external Hack ALU.
REQ-006 SHALL have ports alu_o (in, 16), alu_zr (in, 1), alu_ng (in, 1): returned from the external ALU.
REQ-007 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-008 SHALL decode cmd_op to {zx,nx,zy,ny,f,no}: 0:0=101010, 1:1=111111, 2:-1=111010, 3:x=001100, 4:y=110000, 5:~x=001101, 6:~y=110001, 7:-x=001111, 8:-y=110011, 9:x+1=011111, 10:y+1=110111, 11:x+y=000010, 12:x-y=010011, 13:y-x=000111, 14:x&y=000000, 15:x|y=010101.
REQ-009 SHALL treat cmd_op 16 as MUL (see Configuration) and cmd_op 17..31 as illegal.
REQ-010 SHALL implement FSM states IDLE, EXEC, MUL, RESP.
REQ-011 SHALL assert cmd_ready only in IDLE; a command is accepted on a rising edge with cmd_valid and cmd_ready both high, latching op, x, y.
REQ-012 IDLE: legal op 0..15 -> EXEC; MUL -> MUL; illegal op -> RESP with rsp_o=0, rsp_zr=1, rsp_ng=0, rsp_err=1.
REQ-013 EXEC: drive decoded controls with alu_x/alu_y = latched x/y for exactly one cycle; at the next edge capture alu_o/alu_zr/alu_ng into rsp_o/rsp_zr/rsp_ng, rsp_err=0, go to RESP.
REQ-014 Single-op latency: rsp_valid SHALL rise on the second rising edge after the accepting edge (accept edge counted as first... i.e. one EXEC cycle between).
REQ-015 RESP: hold rsp_valid=1 and all rsp_* stable until an edge with rsp_ready=1, then go to IDLE; rsp_valid SHALL be 0 in every other state.
REQ-016 MUL: shift-add over exactly 16 cycles using a 4-bit iteration counter; acc initialised to 0, mcand=x, mplier=y on acceptance.
REQ-017 Each MUL cycle: alu_x=acc, alu_y=mcand; controls=000010 (x+y) if mplier[0]=1, else 001100 (pass x); at the edge acc<=alu_o, mcand<=mcand<<1, mplier<=mplier>>1, and alu_zr/alu_ng captured.
REQ-018 After the 16th MUL cycle SHALL go to RESP with rsp_o = low 16 bits of x*y (unsigned, wraps), flags from the final captured alu_zr/alu_ng, rsp_err=0.
REQ-019 Outside EXEC/MUL SHALL drive controls 101010 and alu_x=alu_y=0.
REQ-020 A new command SHALL NOT be accepted in the same cycle a response is consumed; IDLE is always visited for at least one cycle.

Reset
REQ-021 rst high SHALL immediately force state IDLE, cmd_ready=1, rsp_valid=0, rsp_o=0, rsp_zr=0, rsp_ng=0, rsp_err=0, busy=0, counter, acc, mcand, mplier=0, controls=101010.
REQ-022 Reset asserted mid-EXEC, mid-MUL or in RESP SHALL discard the operation; no response is produced for it after release.

Configuration
REQ-023 Macro ALU_SEQ_MUL_EN SHALL compile in the MUL state, counter and shift registers.
REQ-024 Without ALU_SEQ_MUL_EN, cmd_op 16 SHALL be illegal (rsp_err=1 path of REQ-012) and no MUL logic is synthesised; ops 0..15 unchanged.

Verification
REQ-025 op=11, x=0x0005, y=0x0003, rsp_ready=1 -> rsp_o=0x0008, zr=0, ng=0, err=0, rsp_valid one EXEC cycle after accept.
REQ-026 op=12, x=3, y=5 -> rsp_o=0xFFFE, ng=1; op=0 -> rsp_o=0, zr=1.
REQ-027 op=20 -> rsp_err=1, rsp_o=0, zr=1; rsp_ready held low 5 cycles -> rsp_valid and data stable throughout, cmd_ready=0.
REQ-028 With ALU_SEQ_MUL_EN: op=16, x=0x0123, y=0x0010 -> rsp_o=0x1230 after 16 MUL cycles; x=0xFFFF, y=0xFFFF -> rsp_o=0x0001; without macro op=16 -> rsp_err=1.
REQ-029 Assert rst during MUL cycle 7 -> all outputs at reset values immediately; after release, no rsp_valid until a new command.
REQ-030 Back-to-back commands with cmd_valid held high -> each accepted only in IDLE, responses in order, one IDLE cycle between.
